// File: rtl/offchip_mem_pkg.sv
// Shared helpers for the off-chip memory model: address windowing, byte-mask
// generation and default latencies.
package offchip_mem_pkg;

    localparam int DEFAULT_READ_LAT  = 2;
    localparam int DEFAULT_WRITE_LAT = 1;

    function automatic logic addr_hit(input longint unsigned addr,
                                      input longint unsigned base,
                                      input longint unsigned words);
        return (addr >= base) && (addr < base + words);
    endfunction

    // Sizes at or beyond the data width select the whole word.
    function automatic logic [63:0] size_mask(input int unsigned size,
                                              input int unsigned data_w);
        if (size >= data_w) begin
            return '1;
        end
        return (64'd1 << size) - 64'd1;
    endfunction

endpackage

// File: rtl/offchip_mem_port.sv
// One master port: wait counter, hit/latency decode, completion strobes and
// write mask for a single channel.
module offchip_mem_port
    import offchip_mem_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 8,
    parameter int SIZE_W    = 4,
    parameter int MEMSIZE   = 32,
    parameter int BASE_ADDR = 0,
    parameter int READ_LAT  = DEFAULT_READ_LAT,
    parameter int WRITE_LAT = DEFAULT_WRITE_LAT,
    parameter int IDX_W     = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              oe,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [SIZE_W-1:0] size,
    output logic              rd_done,
    output logic              wr_done,
    output logic              conflict,
    output logic [IDX_W-1:0]  index,
    output logic [DATA_W-1:0] mask
);

    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit, rd_req, wr_req, rd_last, wr_last;

    always_comb begin
        hit      = addr_hit(64'(addr), 64'(BASE_ADDR), 64'(MEMSIZE));
        conflict = oe & we;
        // A conflicting or out-of-window request behaves exactly like idle.
        rd_req   = oe & ~we & hit;
        wr_req   = we & ~oe & hit;
        rd_last  = rd_req && (cnt_q == CNT_W'(READ_LAT - 1));
        wr_last  = wr_req && (cnt_q == CNT_W'(WRITE_LAT - 1));
        // NOTE: completions are gated by the async reset so outputs drop the
        // moment reset asserts, not at the next clock edge.
        rd_done  = rd_last & reset;
        wr_done  = wr_last & reset;

        cnt_d = '0;
        if ((rd_req || wr_req) && !(rd_last || wr_last)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        index = IDX_W'(32'(addr) - 32'(BASE_ADDR));
        mask  = DATA_W'(size_mask(32'(size), 32'(DATA_W)));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/offchip_mem_model.sv
// Multi-port off-chip memory model: shared array, write-priority merge,
// preload path, sticky protocol-error flags and completed-access counter.
module offchip_mem_model
    import offchip_mem_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 8,
    parameter int SIZE_W    = 4,
    parameter int MEMSIZE   = 32,
    parameter int BASE_ADDR = 0,
    parameter int READ_LAT  = DEFAULT_READ_LAT,
    parameter int WRITE_LAT = DEFAULT_WRITE_LAT
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          Mout_oe_ram,
    input  logic [CHANNELS-1:0]          Mout_we_ram,
    input  logic [CHANNELS*ADDR_W-1:0]   Mout_addr_ram,
    input  logic [CHANNELS*DATA_W-1:0]   Mout_Wdata_ram,
    input  logic [CHANNELS*SIZE_W-1:0]   Mout_data_ram_size,
    input  logic                         load_en,
    input  logic [ADDR_W-1:0]            load_addr,
    input  logic [DATA_W-1:0]            load_data,
    output logic [CHANNELS*DATA_W-1:0]   M_Rdata_ram,
    output logic [CHANNELS-1:0]          M_DataRdy,
    output logic                         err_conflict,
    output logic [CHANNELS-1:0]          err_chan,
    output logic [31:0]                  access_cnt
);

    localparam int IDX_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

    logic [CHANNELS-1:0] rd_done, wr_done, conflict;
    logic [IDX_W-1:0]    index [CHANNELS];
    logic [DATA_W-1:0]   mask  [CHANNELS];

    logic [DATA_W-1:0]   mem_q [MEMSIZE];
    logic [DATA_W-1:0]   mem_d [MEMSIZE];
    logic [CHANNELS-1:0] err_chan_q, err_chan_d;
    logic [31:0]         access_cnt_q, access_cnt_d;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_port
        offchip_mem_port #(
            .ADDR_W   (ADDR_W),
            .DATA_W   (DATA_W),
            .SIZE_W   (SIZE_W),
            .MEMSIZE  (MEMSIZE),
            .BASE_ADDR(BASE_ADDR),
            .READ_LAT (READ_LAT),
            .WRITE_LAT(WRITE_LAT),
            .IDX_W    (IDX_W)
        ) u_port (
            .clock   (clock),
            .reset   (reset),
            .oe      (Mout_oe_ram[c]),
            .we      (Mout_we_ram[c]),
            .addr    (Mout_addr_ram[c*ADDR_W +: ADDR_W]),
            .size    (Mout_data_ram_size[c*SIZE_W +: SIZE_W]),
            .rd_done (rd_done[c]),
            .wr_done (wr_done[c]),
            .conflict(conflict[c]),
            .index   (index[c]),
            .mask    (mask[c])
        );
    end

    // Channels merge in ascending order so the highest index wins a shared
    // word; preload is applied last and overrides every channel.
    always_comb begin
        mem_d = mem_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_done[c]) begin
                mem_d[index[c]] = (Mout_Wdata_ram[c*DATA_W +: DATA_W] & mask[c]) |
                                  (mem_d[index[c]] & ~mask[c]);
            end
        end
        if (load_en && (32'(load_addr) < 32'(MEMSIZE))) begin
            mem_d[load_addr[IDX_W-1:0]] = load_data;
        end
    end

    always_comb begin
        M_DataRdy   = rd_done | wr_done;
        M_Rdata_ram = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rd_done[c]) begin
                M_Rdata_ram[c*DATA_W +: DATA_W] = mem_q[index[c]];
            end
        end
    end

    always_comb begin
        err_chan_d   = err_chan_q | conflict;
        access_cnt_d = access_cnt_q;
        for (int c = 0; c < CHANNELS; c++) begin
            access_cnt_d = access_cnt_d + 32'(M_DataRdy[c]);
        end
    end

    // NOTE: the array has no reset; its content comes only from preload and
    // writes, like a real external memory.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_chan_q   <= '0;
            access_cnt_q <= '0;
        end else begin
            err_chan_q   <= err_chan_d;
            access_cnt_q <= access_cnt_d;
        end
    end

    assign err_chan     = err_chan_q;
    assign err_conflict = |err_chan_q;
    assign access_cnt   = access_cnt_q;

endmodule

// File: tb/tb_offchip_mem_model.sv
// Directed and randomized checks of offchip_mem_model against an array-based
// reference of the memory contents and completed-access count.
module tb_offchip_mem_model;

    localparam int CH   = 2;
    localparam int AW   = 7;
    localparam int DW   = 8;
    localparam int SW   = 4;
    localparam int MS   = 32;
    localparam int BASE = 4;
    localparam int RL   = 2;
    localparam int WL   = 1;

    logic             clock;
    logic             reset;
    logic [CH-1:0]    oe, we;
    logic [CH*AW-1:0] addr;
    logic [CH*DW-1:0] wdata;
    logic [CH*SW-1:0] size;
    logic             load_en;
    logic [AW-1:0]    load_addr;
    logic [DW-1:0]    load_data;
    logic [CH*DW-1:0] rdata;
    logic [CH-1:0]    rdy;
    logic             err_conflict;
    logic [CH-1:0]    err_chan;
    logic [31:0]      access_cnt;

    logic [DW-1:0] ref_mem [MS];
    int            exp_cnt;
    int            checks;
    int            errors;

    offchip_mem_model #(
        .CHANNELS (CH),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .SIZE_W   (SW),
        .MEMSIZE  (MS),
        .BASE_ADDR(BASE),
        .READ_LAT (RL),
        .WRITE_LAT(WL)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .Mout_oe_ram       (oe),
        .Mout_we_ram       (we),
        .Mout_addr_ram     (addr),
        .Mout_Wdata_ram    (wdata),
        .Mout_data_ram_size(size),
        .load_en           (load_en),
        .load_addr         (load_addr),
        .load_data         (load_data),
        .M_Rdata_ram       (rdata),
        .M_DataRdy         (rdy),
        .err_conflict      (err_conflict),
        .err_chan          (err_chan),
        .access_cnt        (access_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_mask(input int sz);
        return (sz >= DW) ? {DW{1'b1}} : DW'((1 << sz) - 1);
    endfunction

    task automatic drive(input int ch, input bit rd, input bit wr, input int a,
                         input logic [DW-1:0] d, input int sz);
        oe[ch]             = rd;
        we[ch]             = wr;
        addr[ch*AW +: AW]  = AW'(a);
        wdata[ch*DW +: DW] = d;
        size[ch*SW +: SW]  = SW'(sz);
    endtask

    task automatic release_ch(input int ch);
        oe[ch] = 1'b0;
        we[ch] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input int idx, input logic [DW-1:0] d);
        load_en   = 1'b1;
        load_addr = AW'(idx);
        load_data = d;
        tick();
        load_en   = 1'b0;
        ref_mem[idx] = d;
    endtask

    // One held request on one channel; a miss is held 5 cycles and must never complete.
    task automatic access(input int ch, input bit rd, input int a,
                          input logic [DW-1:0] d, input int sz);
        bit hit;
        bit exp_rdy;
        int lat;
        int n;
        hit = (a >= BASE) && (a < BASE + MS);
        lat = rd ? RL : WL;
        n   = hit ? lat : 5;
        drive(ch, rd, !rd, a, d, sz);
        for (int cyc = 1; cyc <= n; cyc++) begin
            #1;
            exp_rdy = hit && (cyc == lat);
            check($sformatf("rdy ch%0d addr%0d cyc%0d", ch, a, cyc), 32'(rdy[ch]), 32'(exp_rdy));
            if (rd) begin
                check($sformatf("rdata ch%0d addr%0d cyc%0d", ch, a, cyc),
                      32'(rdata[ch*DW +: DW]), exp_rdy ? 32'(ref_mem[a-BASE]) : 32'd0);
            end
            tick();
            if (exp_rdy) begin
                exp_cnt++;
                if (!rd) begin
                    ref_mem[a-BASE] = (d & ref_mask(sz)) | (ref_mem[a-BASE] & ~ref_mask(sz));
                end
            end
        end
        release_ch(ch);
        check("access_cnt", access_cnt, 32'(exp_cnt));
    endtask

    initial begin
        logic [DW-1:0] old;
        checks = 0; errors = 0; exp_cnt = 0;
        oe = '0; we = '0; addr = '0; wdata = '0; size = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, BASE + 3, 8'h00, 8);
        #12;
        check("reset rdy", 32'(rdy), 32'd0);
        check("reset rdata", 32'(rdata), 32'd0);
        check("reset access_cnt", access_cnt, 32'd0);
        check("reset err_conflict", 32'(err_conflict), 32'd0);
        check("reset err_chan", 32'(err_chan), 32'd0);
        release_ch(0);
        tick();
        reset = 1'b1;

        for (int i = 0; i < MS; i++) preload(i, DW'($urandom));
        preload(3, 8'hA5);
        preload(5, 8'h00);

        access(0, 1'b1, BASE + 3, 8'h00, 8);
        check("word3 readback count", access_cnt, 32'd1);

        access(1, 1'b0, BASE + 5, 8'hFF, 4);
        access(1, 1'b1, BASE + 5, 8'h00, 8);
        check("word5 model", 32'(ref_mem[5]), 32'h0F);
        access(1, 1'b0, BASE + 5, 8'hAA, 0);
        access(0, 1'b1, BASE + 5, 8'h00, 8);

        drive(0, 1'b0, 1'b1, BASE + 7, 8'h11, 8);
        drive(1, 1'b0, 1'b1, BASE + 7, 8'h22, 8);
        #1;
        check("dual write rdy", 32'(rdy), 32'h3);
        tick();
        release_ch(0); release_ch(1);
        ref_mem[7] = 8'h22; exp_cnt += 2;
        access(0, 1'b1, BASE + 7, 8'h00, 8);

        drive(0, 1'b0, 1'b1, BASE + 7, 8'h11, 8);
        drive(1, 1'b0, 1'b1, BASE + 7, 8'h22, 8);
        load_en = 1'b1; load_addr = 7; load_data = 8'h33;
        tick();
        load_en = 1'b0;
        release_ch(0); release_ch(1);
        ref_mem[7] = 8'h33; exp_cnt += 2;
        access(1, 1'b1, BASE + 7, 8'h00, 8);

        old = ref_mem[9];
        drive(0, 1'b1, 1'b0, BASE + 9, 8'h00, 8);
        #1;
        check("rw same word cyc1 rdy", 32'(rdy), 32'd0);
        tick();
        drive(1, 1'b0, 1'b1, BASE + 9, 8'h5C, 8);
        #1;
        check("rw same word rdy", 32'(rdy), 32'h3);
        check("rw same word old data", 32'(rdata[DW-1:0]), 32'(old));
        tick();
        release_ch(0); release_ch(1);
        ref_mem[9] = 8'h5C; exp_cnt += 2;
        access(1, 1'b1, BASE + 9, 8'h00, 8);

        drive(0, 1'b1, 1'b1, BASE + 2, 8'h77, 8);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("conflict no rdy", 32'(rdy), 32'd0);
            tick();
        end
        check("conflict flag", 32'(err_conflict), 32'd1);
        check("conflict chan", 32'(err_chan), 32'h1);
        release_ch(0);
        tick();
        tick();
        check("conflict sticky flag", 32'(err_conflict), 32'd1);
        check("conflict sticky chan", 32'(err_chan), 32'h1);
        check("conflict access_cnt", access_cnt, 32'(exp_cnt));

        access(0, 1'b1, BASE + MS, 8'h00, 8);
        access(1, 1'b0, BASE - 1, 8'h3C, 8);

        drive(1, 1'b1, 1'b0, BASE + 4, 8'h00, 8);
        #1;
        check("dropped read rdy", 32'(rdy), 32'd0);
        tick();
        release_ch(1);
        tick();
        access(1, 1'b1, BASE + 4, 8'h00, 8);

        for (int i = 0; i < 60; i++) begin
            access(int'($urandom_range(0, CH - 1)), bit'($urandom_range(0, 1)),
                   int'($urandom_range(0, BASE + MS + 3)), DW'($urandom),
                   int'($urandom_range(0, 9)));
        end

        drive(0, 1'b1, 1'b0, BASE + 3, 8'h00, 8);
        #1;
        check("abort cyc1 rdy", 32'(rdy), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("abort rdy forced", 32'(rdy), 32'd0);
        check("abort rdata forced", 32'(rdata), 32'd0);
        check("abort access_cnt", access_cnt, 32'd0);
        check("abort err_conflict", 32'(err_conflict), 32'd0);
        check("abort err_chan", 32'(err_chan), 32'd0);
        release_ch(0);
        tick();
        reset = 1'b1;
        exp_cnt = 0;
        access(0, 1'b1, BASE + 3, 8'h00, 8);
        check("reissue access_cnt", access_cnt, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/offchip_mem_model.md
# offchip_mem_model

Parametrised off-chip memory model for the HLS simulation harness. It serves CHANNELS independent master ports with byte-masked writes, configurable read and write latency, and base-address windowing. It flags protocol violations in sticky status instead of aborting. It sits between the accelerator's Mout_* bus and the M_Rdata_ram/M_DataRdy return path, in place of per-testbench inline memory logic.

## Interface
- CHANNELS, 2, number of memory ports
- ADDR_W, 7, word-address bits per channel
- DATA_W, 8, data bits per channel
- SIZE_W, 4, access-size field bits per channel
- MEMSIZE, 32, words in array
- BASE_ADDR, 0, first mapped word address
- READ_LAT, 2, read latency in cycles (≥1)
- WRITE_LAT, 1, write latency in cycles (≥1)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- Mout_oe_ram  in  CHANNELS  read request per channel
- Mout_we_ram  in  CHANNELS  write request per channel
- Mout_addr_ram  in  CHANNELS*ADDR_W  word address, channel c at [c*ADDR_W +: ADDR_W]
- Mout_Wdata_ram  in  CHANNELS*DATA_W  write data
- Mout_data_ram_size  in  CHANNELS*SIZE_W  valid low bits of access
- load_en  in  1  preload strobe
- load_addr  in  ADDR_W  preload word offset (0..MEMSIZE-1)
- load_data  in  DATA_W  preload word
- M_Rdata_ram  out  CHANNELS*DATA_W  read data
- M_DataRdy  out  CHANNELS  access complete
- err_conflict  out  1  sticky: oe and we both high on one channel
- err_chan  out  CHANNELS  sticky per-channel conflict mask
- access_cnt  out  32  completed accesses, all channels

## Operation
- Hit: BASE_ADDR ≤ addr < BASE_ADDR+MEMSIZE. Index = addr−BASE_ADDR.
- Miss: no response. M_DataRdy stays 0, data is 0, no write.
- Per channel, wait counter cnt (0..max(READ_LAT,WRITE_LAT)−1).
- Request protocol: the master holds oe/we, addr, data and size stable until M_DataRdy.
- Read: cnt increments each cycle while hit oe is held.
  - M_DataRdy[c] = 1 when cnt==READ_LAT−1.
  - Same cycle, M_Rdata_ram[c] = array[index] (combinational); 0 otherwise.
  - cnt returns to 0 at that edge.
- Write: same counting against WRITE_LAT−1.
  - On the DataRdy edge, word ← (Wdata & mask) | (word & ~mask).
  - mask = size ≥ DATA_W ? all ones : (1<<size)−1. Size 0 writes nothing but still completes.
- Request dropped before DataRdy: cnt clears next edge, no write.
- Conflict (oe&we on channel c):
  - err_conflict and err_chan[c] set, sticky until reset.
  - The channel is treated as idle: cnt cleared, no DataRdy.
- Same-word writes completing in one edge: highest channel index wins. Preload beats all channel writes.
- Read and write to the same word in the same cycle: the read returns the old value.
- access_cnt += popcount(M_DataRdy) per edge, wrapping at 2^32.
- Array content is not reset. It is initialised only by preload.

## Timing
- Reset low, asynchronous: cnt=0, err_*=0, access_cnt=0.
- Outputs are forced to 0 while reset is low: M_DataRdy=0, M_Rdata_ram=0.
- READ_LAT=1: DataRdy in the request's first cycle (zero-wait). READ_LAT=N: DataRdy in cycle N of the held request.
- Back-to-back: a new request may start the cycle after DataRdy, giving one access per READ_LAT cycles per channel.
- Preload commits at the rising edge with load_en=1. It is visible to reads in the next cycle.
- Reset mid-access aborts it with no write. The master must reissue.

## Structure
- Package offchip_mem_pkg holds:
  - mask function (size→DATA_W mask)
  - hit function
  - default latency constants
- Sub-module offchip_mem_port: per-channel counter, hit/latency decode, DataRdy and mask generation. Instantiate it CHANNELS times with a generate loop.
- Top level holds the array, write-priority merge, preload, error flags and access counter.

## Test plan
- Preload word 3 = 8'hA5, then ch0 read addr BASE+3 with READ_LAT=2 -> DataRdy[0] exactly in second held cycle, Rdata[7:0]=8'hA5, access_cnt=1.
- ch1 write 8'hFF with size 4 to word 5, which holds 8'h00 -> after DataRdy word 5 reads 8'h0F. Size 0 write -> word unchanged, DataRdy still pulses.
- ch0 and ch1 both write word 7, values 8'h11 and 8'h22, completing on one edge -> word 7 = 8'h22. The same edge with load_en to word 7 = 8'h33 -> 8'h33.
- ch0 oe=we=1 -> err_conflict=1, err_chan=2'b01, no DataRdy. Persists after the request clears, and clears only on reset.
- Read addr BASE+MEMSIZE (miss) held 5 cycles -> DataRdy=0, Rdata=0, access_cnt unchanged.
- Assert reset mid-read at cnt=1, release, reissue -> full READ_LAT wait again. access_cnt resets to 0.
